// File: rtl/router_pkg.sv
// Shared router definitions: packet field offsets, reader FSM states and pointer helpers.
package router_pkg;

  localparam int DEST_IDX      = 0;
  localparam int LEN_IDX       = 1;
  localparam int HDR_BYTES     = 2;
  localparam int TRAILER_BYTES = 1;

  // Wide enough for any FIFO pointer in the router; callers zero-extend.
  localparam int PTR_CMP_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } rd_state_t;

  function automatic logic is_empty(input logic [PTR_CMP_W-1:0] rd,
                                    input logic [PTR_CMP_W-1:0] wr);
    return rd == wr;
  endfunction

endpackage

// File: rtl/fifo_packet_reader.sv
// Read side of the router packet FIFO: walks an entry byte by byte, streams it on a
// valid/ready byte bus, checks length and parity, then retires the entry to the writer.
module fifo_packet_reader
  import router_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PTR_SZ:0]      wr_ptr,
  output logic [PTR_SZ:0]      rd_ptr,
  output logic                 read_en,
  output logic [PTR_SZ-1:0]    raddr,
  output logic [PTR_IN_SZ-1:0] raddr_in,
  input  logic [UWIDTH-1:0]    rdata,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 out_len_err,
  output logic                 out_parity_err,
  output logic                 busy
);

  localparam int MAX_PAYLOAD = WIDTH - HDR_BYTES - TRAILER_BYTES;

  rd_state_t            state;
  logic [PTR_IN_SZ-1:0] idx;
  logic [PTR_IN_SZ-1:0] last;
  logic [UWIDTH-1:0]    acc;
  logic                 len_flag;
  logic                 fetch;
  logic                 at_last;

  function automatic logic len_over(input logic [UWIDTH-1:0] len);
    return len > UWIDTH'(MAX_PAYLOAD);
  endfunction

  // Index of the parity byte once the length field is known, clamped to the entry size.
  function automatic logic [PTR_IN_SZ-1:0] clamp_last(input logic [UWIDTH-1:0] len);
    if (len_over(len)) return PTR_IN_SZ'(MAX_PAYLOAD + HDR_BYTES);
    return PTR_IN_SZ'(len) + PTR_IN_SZ'(HDR_BYTES);
  endfunction

  function automatic logic [PTR_SZ:0] next_ptr(input logic [PTR_SZ:0] ptr);
    if (ptr[PTR_SZ-1:0] == PTR_SZ'(DEPTH - 1)) return {~ptr[PTR_SZ], {PTR_SZ{1'b0}}};
    return ptr + 1'b1;
  endfunction

  // The read strobe only exists in the cycle whose byte is captured, so the
  // memory is never read while the writer may be filling another entry.
  always_comb begin
    fetch   = 1'b0;
    if (resetn && (state == STREAM) && (idx <= last) && (!out_valid || out_ready))
      fetch = 1'b1;
    at_last  = (idx == last);
    read_en  = fetch;
    raddr    = rd_ptr[PTR_SZ-1:0];
    raddr_in = idx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      idx            <= '0;
      last           <= PTR_IN_SZ'(HDR_BYTES);
      acc            <= '0;
      len_flag       <= 1'b0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_sop        <= 1'b0;
      out_eop        <= 1'b0;
      out_len_err    <= 1'b0;
      out_parity_err <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (!is_empty(PTR_CMP_W'(rd_ptr), PTR_CMP_W'(wr_ptr))) begin
            state    <= STREAM;
            busy     <= 1'b1;
            idx      <= '0;
            last     <= PTR_IN_SZ'(HDR_BYTES);
            acc      <= '0;
            len_flag <= 1'b0;
          end
        end

        STREAM: begin
          if (fetch) begin
            out_data       <= rdata;
            out_valid      <= 1'b1;
            out_sop        <= (idx == PTR_IN_SZ'(DEST_IDX));
            out_eop        <= at_last;
            out_len_err    <= at_last && len_flag;
            out_parity_err <= at_last && (acc != rdata);
            idx            <= idx + 1'b1;
            if (!at_last)
              acc <= acc ^ rdata;
            if (idx == PTR_IN_SZ'(LEN_IDX)) begin
              last     <= clamp_last(rdata);
              len_flag <= len_over(rdata);
            end
            if (at_last)
              state <= DRAIN;
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid      <= 1'b0;
            out_sop        <= 1'b0;
            out_eop        <= 1'b0;
            out_len_err    <= 1'b0;
            out_parity_err <= 1'b0;
            rd_ptr         <= next_ptr(rd_ptr);
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_packet_reader.sv
// Directed bench for fifo_packet_reader: table of packets plus back-to-back and reset corner cases.
module tb_fifo_packet_reader;

  localparam int DEPTH     = 4;
  localparam int WIDTH     = 11;
  localparam int UWIDTH    = 8;
  localparam int PTR_SZ    = 2;
  localparam int PTR_IN_SZ = 4;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [PTR_SZ:0]      wr_ptr;
  logic [PTR_SZ:0]      rd_ptr;
  logic                 read_en;
  logic [PTR_SZ-1:0]    raddr;
  logic [PTR_IN_SZ-1:0] raddr_in;
  logic [UWIDTH-1:0]    rdata;
  logic [UWIDTH-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_len_err;
  logic                 out_parity_err;
  logic                 busy;

  logic [7:0] mem [DEPTH][WIDTH];

  fifo_packet_reader #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .UWIDTH(UWIDTH), .PTR_SZ(PTR_SZ), .PTR_IN_SZ(PTR_IN_SZ)
  ) dut (
    .clk(clk), .resetn(resetn), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .read_en(read_en),
    .raddr(raddr), .raddr_in(raddr_in), .rdata(rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_len_err(out_len_err), .out_parity_err(out_parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rdata = (raddr_in < 4'(WIDTH)) ? mem[raddr][raddr_in] : 8'h00;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_en_cnt = 0;
  int ready_mode = 0;
  int rphase = 0;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       le;
    logic       pe;
    int         cyc;
  } cap_t;
  cap_t cap_q[$];

  typedef struct {
    logic [87:0] bytes;
    int          n_out;
    logic        le;
    logic        pe;
    int          mode;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: constant 1, or the repeating pattern 1,0,0,1.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) begin
        out_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
        rphase++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Output monitor: captures accepted bytes and checks stability under backpressure.
  initial begin
    logic       stall;
    logic [11:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (read_en) rd_en_cnt++;
      if (stall && resetn) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_bus", 32'({out_data, out_sop, out_eop, out_len_err, out_parity_err}), 32'(held));
      end
      if (resetn && out_valid && !out_ready)
        chk("stall_read_en", 32'(read_en), 32'd0);
      if (resetn && out_valid && out_ready)
        cap_q.push_back('{out_data, out_sop, out_eop, out_len_err, out_parity_err, cyc});
      stall = resetn && out_valid && !out_ready;
      held  = {out_data, out_sop, out_eop, out_len_err, out_parity_err};
    end
  end

  initial begin
    logic [2:0] exp_rd;
    logic [2:0] prev;
    logic [2:0] seen [4];
    logic [7:0] sops [$];
    int         nseen;
    int         ent;
    int         n;
    int         pe_cnt;
    bit         done;

    vecs[0] = '{88'h05_02_AA_55_F8_00_00_00_00_00_00,  5, 1'b0, 1'b0, 0};
    vecs[1] = '{88'h05_02_AA_55_F8_00_00_00_00_00_00,  5, 1'b0, 1'b0, 1};
    vecs[2] = '{88'h05_02_AA_55_FB_00_00_00_00_00_00,  5, 1'b0, 1'b1, 0};
    vecs[3] = '{88'h01_0F_10_11_12_13_14_15_16_17_0E, 11, 1'b1, 1'b0, 0};
    vecs[4] = '{88'h03_00_03_00_00_00_00_00_00_00_00,  3, 1'b0, 1'b0, 1};
    vecs[5] = '{88'h02_08_01_02_04_08_10_20_40_80_F5, 11, 1'b0, 1'b0, 0};

    for (int e = 0; e < DEPTH; e++)
      for (int i = 0; i < WIDTH; i++) mem[e][i] = 8'h00;

    resetn = 1'b0;
    wr_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    resetn = 1'b1;
    rd_en_cnt = 0;

    repeat (8) @(posedge clk);
    #1;
    chk("empty_out_valid", 32'(out_valid), 32'd0);
    chk("empty_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("empty_read_en_count", 32'(rd_en_cnt), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      ent = int'(wr_ptr[1:0]);
      for (int i = 0; i < WIDTH; i++) mem[ent][i] = vecs[v].bytes[87 - 8*i -: 8];
      cap_q.delete();
      ready_mode = vecs[v].mode;
      rphase = 0;
      exp_rd = wr_ptr + 3'd1;
      n = vecs[v].n_out;
      wr_ptr = exp_rd;

      @(posedge clk); #1;
      chk("lat1_out_valid", 32'(out_valid), 32'd0);
      chk("lat1_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk("lat2_out_valid", 32'(out_valid), 32'd1);
      chk("lat2_sop", 32'(out_sop), 32'd1);
      chk("lat2_data", 32'(out_data), 32'(vecs[v].bytes[87 -: 8]));

      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
        if (rd_ptr == exp_rd) done = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      chk("retire_timeout", 32'(done), 32'd1);
      chk("eop_before_retire", 32'(cap_q.size()), 32'(n));

      repeat (3) @(posedge clk);
      #1;
      chk("byte_count", 32'(cap_q.size()), 32'(n));
      for (int i = 0; i < cap_q.size() && i < n; i++) begin
        chk($sformatf("v%0d_data%0d", v, i), 32'(cap_q[i].d), 32'(vecs[v].bytes[87 - 8*i -: 8]));
        chk($sformatf("v%0d_sop%0d", v, i), 32'(cap_q[i].sop), 32'(i == 0));
        chk($sformatf("v%0d_eop%0d", v, i), 32'(cap_q[i].eop), 32'(i == n - 1));
        if (i == n - 1) begin
          chk($sformatf("v%0d_len_err", v), 32'(cap_q[i].le), 32'(vecs[v].le));
          chk($sformatf("v%0d_parity_err", v), 32'(cap_q[i].pe), 32'(vecs[v].pe));
        end
      end
      if (vecs[v].mode == 0 && cap_q.size() == n)
        chk($sformatf("v%0d_throughput", v), 32'(cap_q[n-1].cyc - cap_q[0].cyc), 32'(n - 1));
      chk($sformatf("v%0d_rd_ptr", v), 32'(rd_ptr), 32'(exp_rd));
      chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
    end

    // Four back-to-back packets across the pointer wrap.
    ready_mode = 0;
    resetn = 1'b0;
    wr_ptr = '0;
    @(posedge clk); #1;
    chk("b2b_reset_rd_ptr", 32'(rd_ptr), 32'd0);
    resetn = 1'b1;
    for (int e = 0; e < DEPTH; e++) begin
      mem[e][0] = 8'h10 + 8'(e);
      mem[e][1] = 8'h01;
      mem[e][2] = 8'hAA;
      mem[e][3] = (8'h10 + 8'(e)) ^ 8'h01 ^ 8'hAA;
    end
    cap_q.delete();
    wr_ptr = 3'd4;
    prev = rd_ptr;
    nseen = 0;
    for (int c = 0; c < 400 && nseen < 4; c++) begin
      @(posedge clk); #1;
      if (rd_ptr != prev) begin
        seen[nseen] = rd_ptr;
        nseen++;
        prev = rd_ptr;
      end
    end
    chk("b2b_retire_count", 32'(nseen), 32'd4);
    for (int k = 0; k < nseen; k++)
      chk($sformatf("b2b_rd_ptr%0d", k), 32'(seen[k]), 32'(k + 1));
    pe_cnt = 0;
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i].sop) sops.push_back(cap_q[i].d);
      if (cap_q[i].eop && cap_q[i].pe) pe_cnt++;
    end
    chk("b2b_byte_count", 32'(cap_q.size()), 32'd16);
    chk("b2b_sop_count", 32'(sops.size()), 32'd4);
    for (int k = 0; k < sops.size() && k < 4; k++)
      chk($sformatf("b2b_dest%0d", k), 32'(sops[k]), 32'h10 + 32'(k));
    chk("b2b_parity_errs", 32'(pe_cnt), 32'd0);

    // Reset in the middle of the second packet.
    resetn = 1'b0;
    wr_ptr = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    wr_ptr = 3'd4;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (rd_ptr == 3'd1) done = 1'b1;
    end
    chk("midrst_first_retire", 32'(done), 32'd1);
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk); #1;
      if (out_valid) done = 1'b1;
    end
    chk("midrst_second_start", 32'(done), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    wr_ptr = '0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sop_eop", 32'({out_sop, out_eop}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("midrst_read_en", 32'(read_en), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_rd_ptr", 32'(rd_ptr), 32'd0);
    chk("postrst_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
